// File: rtl/trap_sequencer_pkg.sv
// Shared constants and types for the machine-mode trap sequencer.
// CSR addresses, cause codes, mstatus/mie bit positions, FSM states.
package trap_sequencer_pkg;

  localparam int XLEN             = 32;
  localparam int CSR_ADDR_WIDTH   = 12;
  localparam int EXC_STATUS_WIDTH = 2;

  localparam logic [EXC_STATUS_WIDTH-1:0] EXC_STATUS_IDLE   = 2'd0;
  localparam logic [EXC_STATUS_WIDTH-1:0] EXC_STATUS_ECALL  = 2'd1;
  localparam logic [EXC_STATUS_WIDTH-1:0] EXC_STATUS_EBREAK = 2'd2;
  localparam logic [EXC_STATUS_WIDTH-1:0] EXC_STATUS_MRET   = 2'd3;

  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MSTATUS = 12'h300;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MIE     = 12'h304;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MTVEC   = 12'h305;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MEPC    = 12'h341;
  localparam logic [CSR_ADDR_WIDTH-1:0] CSR_MCAUSE  = 12'h342;

  localparam logic [XLEN-1:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [XLEN-1:0] CAUSE_EBREAK  = 32'd3;
  localparam logic [XLEN-1:0] CAUSE_ECALL   = 32'd11;
  localparam logic [XLEN-1:0] CAUSE_EXT_IRQ = 32'h8000_000B;
  localparam logic [XLEN-1:0] CAUSE_TIM_IRQ = 32'h8000_0007;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  localparam int MIE_MTIE = 7;
  localparam int MIE_MEIE = 11;

  localparam logic [1:0] MTVEC_DIRECT   = 2'b00;
  localparam logic [1:0] MTVEC_VECTORED = 2'b01;

  localparam int TRAP_STATE_WIDTH = 3;

  typedef enum logic [TRAP_STATE_WIDTH-1:0] {
    ST_IDLE        = 3'd0,
    ST_SAVE_EPC    = 3'd1,
    ST_SAVE_CAUSE  = 3'd2,
    ST_SAVE_STATUS = 3'd3,
    ST_RESTORE     = 3'd4,
    ST_REDIRECT    = 3'd5
  } trap_state_e;

endpackage

// File: rtl/trap_sequencer_cause_enc.sv
// Priority encoder for the committing instruction's trap/return event.
// Exceptions beat mret, which beats enabled interrupts.
module trap_cause_enc
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic                        commit_valid_i,
  input  logic [EXC_STATUS_WIDTH-1:0] exc_status_i,
  input  logic                        invalid_i,
  input  logic                        timer_irq_i,
  input  logic                        ext_irq_i,
  input  logic                        mstatus_mie_i,
  input  logic                        mie_mtie_i,
  input  logic                        mie_meie_i,
  output logic                        take_trap_o,
  output logic                        is_mret_o,
  output logic                        is_irq_o,
  output logic [XLEN-1:0]             cause_o
);

  logic ext_en;
  logic tim_en;

  assign ext_en = ext_irq_i & mstatus_mie_i & mie_meie_i;
  assign tim_en = timer_irq_i & mstatus_mie_i & mie_mtie_i;

  always_comb begin
    take_trap_o = 1'b0;
    is_mret_o   = 1'b0;
    is_irq_o    = 1'b0;
    cause_o     = '0;
    if (commit_valid_i) begin
      priority case (1'b1)
        invalid_i: begin
          take_trap_o = 1'b1;
          cause_o     = CAUSE_ILLEGAL;
        end
        exc_status_i == EXC_STATUS_EBREAK: begin
          take_trap_o = 1'b1;
          cause_o     = CAUSE_EBREAK;
        end
        exc_status_i == EXC_STATUS_ECALL: begin
          take_trap_o = 1'b1;
          cause_o     = CAUSE_ECALL;
        end
        exc_status_i == EXC_STATUS_MRET: begin
          is_mret_o = 1'b1;
        end
        ext_en: begin
          take_trap_o = 1'b1;
          is_irq_o    = 1'b1;
          cause_o     = CAUSE_EXT_IRQ;
        end
        tim_en: begin
          take_trap_o = 1'b1;
          is_irq_o    = 1'b1;
          cause_o     = CAUSE_TIM_IRQ;
        end
        default: begin
          take_trap_o = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/mret sequencer: serialises CSR updates over one
// write port, stalls the pipeline, then flushes and redirects fetch.
module trap_sequencer
  import trap_sequencer_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int CSR_ADDR_WIDTH = 12
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        commit_valid,
  input  logic [XLEN-1:0]             commit_pc,
  input  logic [EXC_STATUS_WIDTH-1:0] exc_status,
  input  logic                        invalid_instruction,
  input  logic                        timer_irq,
  input  logic                        ext_irq,
  input  logic [XLEN-1:0]             mstatus_i,
  input  logic [XLEN-1:0]             mie_i,
  input  logic [XLEN-1:0]             mtvec_i,
  input  logic [XLEN-1:0]             mepc_i,
  output logic                        csr_we_o,
  output logic [CSR_ADDR_WIDTH-1:0]   csr_waddr_o,
  output logic [XLEN-1:0]             csr_wdata_o,
  output logic                        trap_kill_o,
  output logic                        trap_stall_o,
  output logic                        trap_flush_o,
  output logic                        redirect_valid_o,
  output logic [XLEN-1:0]             redirect_pc_o
);

  trap_state_e state_q, state_d;

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] mstatus_q, mstatus_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic            irq_q, irq_d;

  logic                      we_q, we_d;
  logic [CSR_ADDR_WIDTH-1:0] waddr_q, waddr_d;
  logic [XLEN-1:0]           wdata_q, wdata_d;
  logic                      flush_q, flush_d;
  logic                      rv_q, rv_d;
  logic [XLEN-1:0]           rpc_q, rpc_d;

  logic            take_trap;
  logic            is_mret;
  logic            is_irq;
  logic [XLEN-1:0] cause;
  logic [XLEN-1:0] trap_status;
  logic [XLEN-1:0] mret_status;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] trap_target;
  logic            unused_bits;

  trap_cause_enc #(.XLEN(XLEN)) u_enc (
    .commit_valid_i (commit_valid),
    .exc_status_i   (exc_status),
    .invalid_i      (invalid_instruction),
    .timer_irq_i    (timer_irq),
    .ext_irq_i      (ext_irq),
    .mstatus_mie_i  (mstatus_i[MSTATUS_MIE]),
    .mie_mtie_i     (mie_i[MIE_MTIE]),
    .mie_meie_i     (mie_i[MIE_MEIE]),
    .take_trap_o    (take_trap),
    .is_mret_o      (is_mret),
    .is_irq_o       (is_irq),
    .cause_o        (cause)
  );

  assign unused_bits = ^{mie_i, mepc_q[1:0]};

  always_comb begin
    trap_status = mstatus_q;
    trap_status[MSTATUS_MPIE] = mstatus_q[MSTATUS_MIE];
    trap_status[MSTATUS_MIE]  = 1'b0;
    trap_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  always_comb begin
    mret_status = mstatus_i;
    mret_status[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
    mret_status[MSTATUS_MPIE] = 1'b1;
    mret_status[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  // Vectored mode offsets only interrupts; modes 1x fall back to direct.
  assign base = {mtvec_q[XLEN-1:2], 2'b00};
  always_comb begin
    trap_target = base;
    if (mtvec_q[1:0] == MTVEC_VECTORED && irq_q)
      trap_target = base + {cause_q[XLEN-3:0], 2'b00};
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    cause_d      = cause_q;
    mstatus_d    = mstatus_q;
    mtvec_d      = mtvec_q;
    mepc_d       = mepc_q;
    irq_d        = irq_q;
    we_d         = 1'b0;
    waddr_d      = '0;
    wdata_d      = '0;
    flush_d      = 1'b0;
    rv_d         = 1'b0;
    rpc_d        = '0;
    trap_stall_o = 1'b0;
    trap_kill_o  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (take_trap || is_mret) begin
          trap_stall_o = 1'b1;
          trap_kill_o  = take_trap;
          pc_d         = commit_pc;
          cause_d      = cause;
          mstatus_d    = mstatus_i;
          mtvec_d      = mtvec_i;
          mepc_d       = mepc_i;
          irq_d        = is_irq;
          we_d         = 1'b1;
          if (take_trap) begin
            state_d = ST_SAVE_EPC;
            waddr_d = CSR_MEPC;
            wdata_d = commit_pc;
          end else begin
            state_d = ST_RESTORE;
            waddr_d = CSR_MSTATUS;
            wdata_d = mret_status;
          end
        end
      end
      ST_SAVE_EPC: begin
        trap_stall_o = 1'b1;
        state_d      = ST_SAVE_CAUSE;
        we_d         = 1'b1;
        waddr_d      = CSR_MCAUSE;
        wdata_d      = cause_q;
      end
      ST_SAVE_CAUSE: begin
        trap_stall_o = 1'b1;
        state_d      = ST_SAVE_STATUS;
        we_d         = 1'b1;
        waddr_d      = CSR_MSTATUS;
        wdata_d      = trap_status;
      end
      ST_SAVE_STATUS: begin
        trap_stall_o = 1'b1;
        state_d      = ST_REDIRECT;
        flush_d      = 1'b1;
        rv_d         = 1'b1;
        rpc_d        = trap_target;
      end
      ST_RESTORE: begin
        trap_stall_o = 1'b1;
        state_d      = ST_REDIRECT;
        flush_d      = 1'b1;
        rv_d         = 1'b1;
        rpc_d        = {mepc_q[XLEN-1:2], 2'b00};
      end
      ST_REDIRECT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      cause_q   <= '0;
      mstatus_q <= '0;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      irq_q     <= 1'b0;
      we_q      <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      flush_q   <= 1'b0;
      rv_q      <= 1'b0;
      rpc_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      cause_q   <= cause_d;
      mstatus_q <= mstatus_d;
      mtvec_q   <= mtvec_d;
      mepc_q    <= mepc_d;
      irq_q     <= irq_d;
      we_q      <= we_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
      flush_q   <= flush_d;
      rv_q      <= rv_d;
      rpc_q     <= rpc_d;
    end
  end

  assign csr_we_o         = we_q;
  assign csr_waddr_o      = waddr_q;
  assign csr_wdata_o      = wdata_q;
  assign trap_flush_o     = flush_q;
  assign redirect_valid_o = rv_q;
  assign redirect_pc_o    = rpc_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: trap, vectored irq, masked irq,
// mret, priority and mid-sequence reset, checked with assertions.
module tb_trap_sequencer;
  import trap_sequencer_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        commit_valid;
  logic [31:0] commit_pc;
  logic [1:0]  exc_status;
  logic        invalid_instruction;
  logic        timer_irq;
  logic        ext_irq;
  logic [31:0] mstatus_i;
  logic [31:0] mie_i;
  logic [31:0] mtvec_i;
  logic [31:0] mepc_i;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic        trap_kill_o;
  logic        trap_stall_o;
  logic        trap_flush_o;
  logic        redirect_valid_o;
  logic [31:0] redirect_pc_o;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  trap_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .commit_valid        (commit_valid),
    .commit_pc           (commit_pc),
    .exc_status          (exc_status),
    .invalid_instruction (invalid_instruction),
    .timer_irq           (timer_irq),
    .ext_irq             (ext_irq),
    .mstatus_i           (mstatus_i),
    .mie_i               (mie_i),
    .mtvec_i             (mtvec_i),
    .mepc_i              (mepc_i),
    .csr_we_o            (csr_we_o),
    .csr_waddr_o         (csr_waddr_o),
    .csr_wdata_o         (csr_wdata_o),
    .trap_kill_o         (trap_kill_o),
    .trap_stall_o        (trap_stall_o),
    .trap_flush_o        (trap_flush_o),
    .redirect_valid_o    (redirect_valid_o),
    .redirect_pc_o       (redirect_pc_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Bundle the single-bit status: {we, kill, stall, flush, rv}
  function automatic logic [31:0] ctl();
    return {27'd0, csr_we_o, trap_kill_o, trap_stall_o,
            trap_flush_o, redirect_valid_o};
  endfunction

  task automatic drive_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    commit_valid        = 1'b0;
    commit_pc           = '0;
    exc_status          = EXC_STATUS_IDLE;
    invalid_instruction = 1'b0;
    timer_irq           = 1'b0;
    ext_irq             = 1'b0;
  endtask

  int   seen_bad;
  logic seen_rv;

  initial begin
    rst = 1'b1;
    idle_inputs();
    mstatus_i = '0;
    mie_i     = '0;
    mtvec_i   = '0;
    mepc_i    = '0;
    drive_edge();
    drive_edge();
    sample();
    chk("reset_ctl", ctl(), 32'h0);
    chk("reset_waddr", {20'd0, csr_waddr_o}, 32'h0);
    chk("reset_wdata", csr_wdata_o, 32'h0);
    chk("reset_rpc", redirect_pc_o, 32'h0);
    drive_edge();
    rst = 1'b0;

    // ecall at 0x100, direct mtvec 0x200
    drive_edge();
    commit_valid = 1'b1;
    exc_status   = EXC_STATUS_ECALL;
    commit_pc    = 32'h100;
    mtvec_i      = 32'h200;
    mstatus_i    = 32'h8;
    sample();
    chk("ecall_T_ctl", ctl(), 32'b01100);
    drive_edge();
    idle_inputs();
    mtvec_i   = 32'h999;
    mstatus_i = 32'h0;
    sample();
    chk("ecall_T1_ctl", ctl(), 32'b10100);
    chk("ecall_T1_addr", {20'd0, csr_waddr_o}, 32'h341);
    chk("ecall_T1_data", csr_wdata_o, 32'h100);
    drive_edge();
    sample();
    chk("ecall_T2_ctl", ctl(), 32'b10100);
    chk("ecall_T2_addr", {20'd0, csr_waddr_o}, 32'h342);
    chk("ecall_T2_data", csr_wdata_o, 32'd11);
    drive_edge();
    sample();
    chk("ecall_T3_ctl", ctl(), 32'b10100);
    chk("ecall_T3_addr", {20'd0, csr_waddr_o}, 32'h300);
    chk("ecall_T3_data", csr_wdata_o, 32'h1880);
    drive_edge();
    sample();
    chk("ecall_T4_ctl", ctl(), 32'b00011);
    chk("ecall_T4_pc", redirect_pc_o, 32'h200);
    chk("ecall_T4_waddr", {20'd0, csr_waddr_o}, 32'h0);
    drive_edge();
    sample();
    chk("ecall_T5_ctl", ctl(), 32'b00000);

    // timer irq, vectored mtvec 0x201
    drive_edge();
    commit_valid = 1'b1;
    commit_pc    = 32'h40;
    timer_irq    = 1'b1;
    mie_i        = 32'h80;
    mstatus_i    = 32'h8;
    mtvec_i      = 32'h201;
    sample();
    chk("tim_T_ctl", ctl(), 32'b01100);
    drive_edge();
    commit_valid = 1'b0;
    sample();
    chk("tim_T1_addr", {20'd0, csr_waddr_o}, 32'h341);
    chk("tim_T1_data", csr_wdata_o, 32'h40);
    drive_edge();
    sample();
    chk("tim_T2_data", csr_wdata_o, 32'h8000_0007);
    drive_edge();
    sample();
    chk("tim_T3_data", csr_wdata_o, 32'h1880);
    drive_edge();
    sample();
    chk("tim_T4_ctl", ctl(), 32'b00011);
    chk("tim_T4_pc", redirect_pc_o, 32'h21C);
    drive_edge();
    idle_inputs();

    // timer irq masked by mstatus.MIE=0
    drive_edge();
    commit_valid = 1'b1;
    commit_pc    = 32'h44;
    timer_irq    = 1'b1;
    mstatus_i    = 32'h0;
    seen_bad     = 0;
    for (int i = 0; i < 20; i++) begin
      sample();
      if (trap_stall_o || csr_we_o || redirect_valid_o || trap_kill_o)
        seen_bad++;
      drive_edge();
    end
    chk("masked_irq_quiet", seen_bad, 32'd0);
    idle_inputs();

    // mret from mepc 0x104
    drive_edge();
    commit_valid = 1'b1;
    exc_status   = EXC_STATUS_MRET;
    mstatus_i    = 32'h1880;
    mepc_i       = 32'h104;
    sample();
    chk("mret_T_ctl", ctl(), 32'b00100);
    drive_edge();
    idle_inputs();
    mepc_i = 32'hFFF;
    sample();
    chk("mret_T1_ctl", ctl(), 32'b10100);
    chk("mret_T1_addr", {20'd0, csr_waddr_o}, 32'h300);
    chk("mret_T1_data", csr_wdata_o, 32'h1888);
    drive_edge();
    sample();
    chk("mret_T2_ctl", ctl(), 32'b00011);
    chk("mret_T2_pc", redirect_pc_o, 32'h104);

    // illegal beats enabled ext irq; exception ignores vectoring
    drive_edge();
    drive_edge();
    commit_valid        = 1'b1;
    commit_pc           = 32'h80;
    invalid_instruction = 1'b1;
    ext_irq             = 1'b1;
    mie_i               = 32'h800;
    mstatus_i           = 32'h8;
    mtvec_i             = 32'h201;
    sample();
    chk("ill_T_ctl", ctl(), 32'b01100);
    drive_edge();
    idle_inputs();
    sample();
    chk("ill_T1_data", csr_wdata_o, 32'h80);
    drive_edge();
    sample();
    chk("ill_T2_data", csr_wdata_o, 32'd2);
    drive_edge();
    sample();
    drive_edge();
    sample();
    chk("ill_T4_ctl", ctl(), 32'b00011);
    chk("ill_T4_pc", redirect_pc_o, 32'h200);

    // ecall aborted by reset during SAVE_CAUSE
    drive_edge();
    drive_edge();
    commit_valid = 1'b1;
    exc_status   = EXC_STATUS_ECALL;
    commit_pc    = 32'h100;
    mtvec_i      = 32'h200;
    mstatus_i    = 32'h8;
    seen_rv      = 1'b0;
    sample();
    drive_edge();
    idle_inputs();
    sample();
    seen_rv = seen_rv | redirect_valid_o;
    drive_edge();
    sample();
    chk("rst_T2_addr", {20'd0, csr_waddr_o}, 32'h342);
    rst = 1'b1;
    drive_edge();
    rst = 1'b0;
    sample();
    chk("rst_after_ctl", ctl(), 32'b00000);
    for (int i = 0; i < 8; i++) begin
      seen_rv = seen_rv | redirect_valid_o;
      drive_edge();
      sample();
    end
    chk("rst_no_redirect", {31'd0, seen_rv}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Machine-mode trap and return sequencer for the pipelined RV32I core.
- Consumes the decoder's exception status and invalid-instruction flag, plus the timer and external interrupt lines, for the instruction at the commit point.
- On a trap it serialises the CSR updates (mepc, mcause, mstatus) through a single CSR write port, stalls the pipeline, then flushes it and redirects fetch.
- On mret it restores mstatus and redirects fetch to mepc.

Parameters:
XLEN, 32, datapath and CSR data width.
CSR_ADDR_WIDTH, 12, CSR address width.

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
commit_valid  in  1  non-bubble instruction present at commit point
commit_pc  in  XLEN  PC of that instruction
exc_status  in  EXC_STATUS_WIDTH  decoder code: IDLE/ECALL/EBREAK/MRET
invalid_instruction  in  1  decoder illegal-instruction flag
timer_irq  in  1  level-sensitive machine timer interrupt
ext_irq  in  1  level-sensitive machine external interrupt
mstatus_i  in  XLEN  current mstatus
mie_i  in  XLEN  current mie (MTIE bit 7, MEIE bit 11)
mtvec_i  in  XLEN  current mtvec
mepc_i  in  XLEN  current mepc
csr_we_o  out  1  CSR write enable
csr_waddr_o  out  CSR_ADDR_WIDTH  CSR write address
csr_wdata_o  out  XLEN  CSR write data
trap_kill_o  out  1  suppress rf_we/ram_we of the committing instruction
trap_stall_o  out  1  freeze all pipeline registers and PC
trap_flush_o  out  1  one-cycle flush of IF/ID/EX
redirect_valid_o  out  1  load redirect_pc_o into PC
redirect_pc_o  out  XLEN  trap or return target

Behaviour:
- Reset is synchronous and active-high on clk. On reset: state=IDLE, and every registered output is 0 (csr_we_o, csr_waddr_o, csr_wdata_o, trap_flush_o, redirect_valid_o, redirect_pc_o).
- Event detection happens only in IDLE with commit_valid=1. Priority: invalid_instruction > EBREAK > ECALL > MRET > ext_irq > timer_irq.
- Interrupts are taken only when mstatus_i[3] (MIE)=1 and the matching mie_i bit is set.
- Cause codes: illegal=2, ebreak=3, ecall=11, external=0x8000000B, timer=0x80000007.
- Detect cycle T (combinational): trap_stall_o=1. trap_kill_o=1 for traps only, never for mret.
- Detect cycle T (registered at the edge): cause, commit_pc, mstatus_i, mtvec_i and mepc_i are captured.
- Trap path: IDLE -> SAVE_EPC (T+1) -> SAVE_CAUSE (T+2) -> SAVE_STATUS (T+3) -> REDIRECT (T+4) -> IDLE.
  - T+1: write 0x341 <= captured pc.
  - T+2: write 0x342 <= cause.
  - T+3: write 0x300 <= captured mstatus with MPIE=old MIE, MIE=0, MPP=2'b11.
- Mret path: IDLE -> RESTORE (T+1) -> REDIRECT (T+2) -> IDLE.
  - T+1: write 0x300 with MIE=old MPIE, MPIE=1, MPP=2'b11.
  - REDIRECT target = captured mepc & ~3.
- Trap target:
  - mtvec mode 00: target = base, where base = mtvec & ~3.
  - mtvec mode 01 with an interrupt: target = base + 4*cause[30:0], computed modulo 2^XLEN.
  - mtvec mode 01 with an exception: target = base.
  - Modes 1x are treated as 00.
- REDIRECT cycle: redirect_valid_o=1, trap_flush_o=1, trap_stall_o=0, csr_we_o=0. All of these last exactly one cycle.
- trap_stall_o=1 in T and in every non-IDLE, non-REDIRECT state.
- csr_we_o=1 only in the SAVE_*/RESTORE states. csr_waddr_o and csr_wdata_o are 0 whenever csr_we_o=0.
- Interrupts asserted or deasserted while the sequencer is busy are ignored. They are re-sampled in IDLE, at the earliest the cycle after REDIRECT.
- Input changes while busy have no effect; captured values are used throughout the sequence.
- Reset in any state: at the next edge state=IDLE and all outputs 0, no redirect is issued, and partial CSR writes stand.
- commit_valid=0: no event, even if irq lines are high.

Decomposition:
- defines.v gains:
  - CSR addresses (CSR_MSTATUS, CSR_MEPC, CSR_MCAUSE, CSR_MTVEC, CSR_MIE).
  - Cause constants.
  - mstatus bit positions (MIE=3, MPIE=7, MPP=12:11).
  - mtvec mode encodings.
  - Trap FSM state encodings with TRAP_STATE_WIDTH.
- Existing EXC_STATUS_* codes are reused unchanged.
- One sub-module, trap_cause_enc: combinational priority encoder giving take_trap, is_mret, is_irq and cause[XLEN-1:0].

Test Plan:
- ecall at pc 0x100, mtvec=0x200, mstatus=0x8 -> T+1 write 0x341<=0x100; T+2 0x342<=11; T+3 0x300<=0x1880; T+4 redirect 0x200 plus flush; stall high T..T+3.
- timer_irq=1, mie=0x80, mstatus=0x8, mtvec=0x201, pc 0x40 -> mepc<=0x40; mcause<=0x80000007; redirect 0x21C; trap_kill_o=1 at T.
- timer_irq=1 with mstatus=0x0 -> no stall, no CSR write, no redirect for 20 cycles.
- mret with mstatus=0x1880, mepc=0x104 -> T+1 write 0x300<=0x1888; T+2 redirect 0x104; trap_kill_o stays 0.
- invalid_instruction and ext_irq (mie=0x800, MIE=1) together at pc 0x80 -> mcause<=2; redirect to base.
- ecall, then rst=1 during SAVE_CAUSE -> next cycle csr_we_o=0 and stall=0; no redirect_valid_o pulse ever seen.
